// File: rtl/updown_modcounter.sv
// updown_modcounter: parametrised up/down modulo counter with clear, load,
// wrap/saturate bounds, cascadable terminal count and sticky overflow.
module updown_modcounter #(
  parameter int unsigned    WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}},
  parameter bit             SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  logic [WIDTH-1:0] cnt_q, cnt_d, step, bound_val;
  logic             wrap_q, wrap_d, ovf_q, ovf_d, bound;
  // A bound event is an enabled count that would leave 0..MAX; it doubles as tc.
  always_comb begin
    bound     = en & (up_dn ? (cnt_q == MAX) : (cnt_q == '0));
    step      = up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
    bound_val = SATURATE ? cnt_q : (up_dn ? '0 : MAX);
    cnt_d     = clr ? '0 :
                load ? ((d > MAX) ? MAX : d) :
                en ? (bound ? bound_val : step) : cnt_q;
    wrap_d    = ~clr & ~load & bound;
    ovf_d     = ~clr & (ovf_q | (~load & bound));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end
  assign q    = cnt_q;
  assign tc   = bound;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_updown_modcounter.sv
// tb_updown_modcounter: wrap and saturate instances against an arithmetic
// reference model, plus a two-stage decade cascade and async reset checks.
module tb_updown_modcounter;
  localparam int MAXV = 9;
  logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1;
  logic [3:0] d = '0;
  logic [3:0] q0, q1, lq, hq;
  logic       tc0, tc1, w0, w1, o0, o1;
  logic       c_en = 1'b0;
  logic       ltc, htc, lw, hw, lo, ho;
  int checks = 0, errors = 0;
  int mq[2], mw[2], mo[2];

  always #5 clk = ~clk;

  updown_modcounter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .up_dn(up_dn),
    .q(q0), .tc(tc0), .wrap(w0), .ovf(o0));
  updown_modcounter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .up_dn(up_dn),
    .q(q1), .tc(tc1), .wrap(w1), .ovf(o1));
  updown_modcounter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_low (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .d(4'd0), .en(c_en), .up_dn(1'b1),
    .q(lq), .tc(ltc), .wrap(lw), .ovf(lo));
  updown_modcounter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) u_high (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .d(4'd0), .en(ltc), .up_dn(1'b1),
    .q(hq), .tc(htc), .wrap(hw), .ovf(ho));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mtc(int i);
    return (en && (up_dn ? mq[i] == MAXV : mq[i] == 0)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mw[i] = 0; mo[i] = 0;
    end
  endtask

  // Instance i saturates when i==1, wraps modulo MAX+1 otherwise.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nq;
      if (clr) begin
        mq[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (load) begin
        mq[i] = (int'(d) > MAXV) ? MAXV : int'(d); mw[i] = 0;
      end else if (en) begin
        nq = up_dn ? mq[i] + 1 : mq[i] - 1;
        if (nq < 0 || nq > MAXV) begin
          mw[i] = 1; mo[i] = 1;
          if (i == 0) mq[i] = (nq + MAXV + 1) % (MAXV + 1);
        end else begin
          mq[i] = nq; mw[i] = 0;
        end
      end else mw[i] = 0;
    end
  endtask

  task automatic cycle();
    #1;
    check("tc_wrap", tc0, mtc(0));
    check("tc_sat", tc1, mtc(1));
    model_step();
    @(posedge clk);
    #1;
    check("q_wrap", q0, mq[0]);
    check("wrap_wrap", w0, mw[0]);
    check("ovf_wrap", o0, mo[0]);
    check("q_sat", q1, mq[1]);
    check("wrap_sat", w1, mw[1]);
    check("ovf_sat", o1, mo[1]);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] dv, input logic e, input logic u, input int n);
    clr = c; load = l; d = dv; en = e; up_dn = u;
    repeat (n) cycle();
  endtask

  initial begin
    int hwraps;
    model_reset();
    en = 1'b1; up_dn = 1'b0;
    #3;
    check("rst_q", q0, 0);
    check("rst_wrap", w0, 0);
    check("rst_ovf", o0, 0);
    check("rst_tc_down", tc0, 1);
    en = 1'b0;
    #1;
    check("rst_tc_off", tc0, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // Free count from reset through the 9->0 wrap.
    drive(0, 0, 0, 1, 1, 12);
    check("free_q", q0, 2);
    check("free_ovf", o0, 1);
    // Down wrap then direction change.
    drive(0, 1, 4'd2, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 4);
    drive(0, 0, 0, 1, 1, 2);
    check("dir_q", q0, 0);
    // Saturation at both bounds.
    drive(0, 1, 4'd8, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 3);
    check("sat_top_q", q1, 9);
    check("sat_top_wrap", w1, 1);
    drive(0, 1, 4'd0, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 2);
    check("sat_bot_q", q1, 0);
    check("sat_bot_wrap", w1, 1);
    // Priority and clamp.
    drive(1, 1, 4'd5, 1, 1, 1);
    check("prio_ovf", o0, 0);
    drive(0, 1, 4'd15, 0, 1, 1);
    check("clamp_q", q0, 9);
    drive(0, 1, 4'd3, 1, 1, 1);
    check("load_en_q", q0, 3);
    // Async reset mid-count at q=6 with ovf set.
    drive(0, 1, 4'd9, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 7);
    check("pre_rst_q", q0, 6);
    check("pre_rst_ovf", o0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q0, 0);
    check("arst_wrap", w0, 0);
    check("arst_ovf", o0, 0);
    model_reset();
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 1);
    check("arst_resume_q", q0, 1);
    // Randomised traffic.
    repeat (400) begin
      clr   = ($urandom_range(0, 24) == 0);
      load  = ($urandom_range(0, 9) == 0);
      d     = 4'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = 1'($urandom);
      cycle();
    end
    // Two-stage decade cascade.
    en = 1'b0; clr = 1'b0; load = 1'b0;
    check("casc_start", hq * 10 + lq, 0);
    hwraps = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      check("casc_val", hq * 10 + lq, i % 100);
      if (hw) hwraps++;
    end
    c_en = 1'b0;
    check("casc_hwrap", hwraps, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
